// File: rtl/apb_slave_regbank.sv
// APB3 completer: bank of 32-bit registers with a read-only ID word, programmable wait states,
// error response on illegal accesses and a saturating protocol-error counter.
module apb_slave_regbank #(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0000,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [7:0]            err_cnt
);

  localparam int unsigned   IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned   WI       = ADDR_WIDTH - 2;
  localparam logic [WI-1:0] LAST_IDX = WI'(NUM_REGS - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    lat_write;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [31:0]             lat_wdata;
  logic [31:0]             regs [NUM_REGS];

  logic [WI-1:0]           lat_idx;
  logic [IDX_W-1:0]        sel;
  logic                    misaligned;
  logic                    out_of_range;
  logic                    id_write;
  logic                    err;
  logic                    done;
  logic [31:0]             rd_val;

  // The full word index is compared so that high address bits never alias onto a register.
  assign lat_idx      = lat_addr[ADDR_WIDTH-1:2];
  assign sel          = lat_addr[IDX_W+1:2];
  assign misaligned   = lat_addr[1:0] != 2'b00;
  assign out_of_range = lat_idx > LAST_IDX;
  assign id_write     = lat_write && (lat_idx == LAST_IDX);
  assign err          = misaligned || out_of_range || id_write;

  assign done    = (state == ACCESS) && (cnt == 4'd0) && !rst;
  assign rd_val  = (lat_idx == LAST_IDX) ? ID_VALUE : regs[sel];
  assign pready  = done;
  assign pslverr = done && err;
  assign prdata  = (done && !lat_write && !err) ? rd_val : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
      err_cnt   <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            lat_write <= pwrite;
            lat_addr  <= paddr;
            lat_wdata <= pwdata;
            cnt       <= 4'(WAIT_CYCLES);
            state     <= ACCESS;
          end else if (psel && penable) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
        end
        ACCESS: begin
          if (psel && penable) begin
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else begin
              if (lat_write && !err) regs[sel] <= lat_wdata;
              state <= IDLE;
            end
          end else begin
            // Master abandoned the transfer: count it and drop the latched request.
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: table of single transfers plus hand-written
// sequences for aborts, saturation, zero-wait instance and mid-transfer reset.
module tb_apb_slave_regbank;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, psel0, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata, prdata0;
  logic        pready, pready0, pslverr, pslverr0;
  logic [7:0]  err_cnt, err_cnt0;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [31:0] ID = 32'hA5B0_0000;

  always #5 clk = ~clk;

  apb_slave_regbank #(.NUM_REGS(8), .WAIT_CYCLES(1), .ID_VALUE(ID), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .err_cnt(err_cnt)
  );

  apb_slave_regbank #(.NUM_REGS(8), .WAIT_CYCLES(0), .ID_VALUE(ID), .ADDR_WIDTH(32)) dut0 (
    .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .err_cnt(err_cnt0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts at posedge+1; leaves the bus idle at posedge+1 right after the completion edge.
  task automatic xfer(input bit inst, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int cyc);
    bit got;
    got   = 1'b0;
    rdata = 32'd0;
    err   = 1'b0;
    if (inst) psel0 = 1'b1; else psel = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    cyc = 1;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst ? pready0 : pready) begin
        rdata = inst ? prdata0 : prdata;
        err   = inst ? pslverr0 : pslverr;
        got   = 1'b1;
        break;
      end
      check("slverr_while_waiting", {31'd0, inst ? pslverr0 : pslverr}, 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    if (!got) check("xfer_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    psel = 1'b0; psel0 = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] rd;
  logic        er;
  int          cyc;

  initial begin
    rst = 1'b1; psel = 1'b0; psel0 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0;

    for (int i = 0; i < 7; i++) vecs.push_back('{1'b0, 32'(i * 4), 32'd0, 32'd0, 1'b0});
    vecs.push_back('{1'b0, 32'h1C, 32'd0, ID, 1'b0});
    vecs.push_back('{1'b1, 32'h04, 32'h0000_0003, 32'd0, 1'b0});
    vecs.push_back('{1'b0, 32'h04, 32'd0, 32'h0000_0003, 1'b0});
    vecs.push_back('{1'b1, 32'h1C, 32'h1234_5678, 32'd0, 1'b1});
    vecs.push_back('{1'b1, 32'h20, 32'h1111_1111, 32'd0, 1'b1});
    vecs.push_back('{1'b1, 32'h06, 32'h2222_2222, 32'd0, 1'b1});
    vecs.push_back('{1'b0, 32'h1C, 32'd0, ID, 1'b0});
    vecs.push_back('{1'b0, 32'h04, 32'd0, 32'h0000_0003, 1'b0});
    vecs.push_back('{1'b0, 32'h00, 32'd0, 32'd0, 1'b0});
    vecs.push_back('{1'b0, 32'h20, 32'd0, 32'd0, 1'b1});
    vecs.push_back('{1'b0, 32'h03, 32'd0, 32'd0, 1'b1});
    vecs.push_back('{1'b1, 32'h18, 32'hCAFE_F00D, 32'd0, 1'b0});
    vecs.push_back('{1'b0, 32'h18, 32'd0, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b0, 32'h1000_0000, 32'd0, 32'd0, 1'b1});
    vecs.push_back('{1'b1, 32'h8000_0004, 32'hBAD0_BAD0, 32'd0, 1'b1});
    vecs.push_back('{1'b0, 32'h04, 32'd0, 32'h0000_0003, 1'b0});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pready", {31'd0, pready}, 32'd0);
    check("reset_pslverr", {31'd0, pslverr}, 32'd0);
    check("reset_prdata", prdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("post_reset_pready", {31'd0, pready}, 32'd0);
    @(posedge clk); #1;

    // Back-to-back table transfers on the one-wait-state instance
    foreach (vecs[i]) begin
      xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, cyc);
      check($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_pslverr", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'd3);
    end
    check("table_err_cnt", {24'd0, err_cnt}, 32'd0);

    // Master drops psel after one access cycle of a write to 0x08
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h0000_0077;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_err_cnt", {24'd0, err_cnt}, 32'd1);
    check("abort_pready", {31'd0, pready}, 32'd0);
    @(posedge clk); #1;
    xfer(1'b0, 1'b0, 32'h08, 32'd0, rd, er, cyc);
    check("abort_no_write", rd, 32'd0);

    // Access without setup, repeatedly: counter must saturate
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h00;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("nosetup_err_cnt_11", {24'd0, err_cnt}, 32'd11);
    check("nosetup_pready", {31'd0, pready}, 32'd0);
    repeat (290) @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("err_cnt_saturated", {24'd0, err_cnt}, 32'hFF);
    @(posedge clk); #1;

    // Zero-wait-state instance
    xfer(1'b1, 1'b1, 32'h0C, 32'hDEAD_BEEF, rd, er, cyc);
    check("w0_write_cycles", 32'(cyc), 32'd2);
    check("w0_write_err", {31'd0, er}, 32'd0);
    xfer(1'b1, 1'b0, 32'h0C, 32'd0, rd, er, cyc);
    check("w0_read_prdata", rd, 32'hDEAD_BEEF);
    check("w0_read_cycles", 32'(cyc), 32'd2);
    check("w0_err_cnt", {24'd0, err_cnt0}, 32'd0);

    // Reset during the wait cycle of a write of 0x55 to 0x10
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h55;
    @(posedge clk); #1;
    penable = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pready_during", {31'd0, pready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("rst_mid_pready_after", {31'd0, pready}, 32'd0);
    check("rst_mid_err_cnt", {24'd0, err_cnt}, 32'd0);
    @(posedge clk); #1;
    xfer(1'b0, 1'b0, 32'h10, 32'd0, rd, er, cyc);
    check("rst_mid_no_write", rd, 32'd0);
    xfer(1'b0, 1'b0, 32'h04, 32'd0, rd, er, cyc);
    check("rst_cleared_reg1", rd, 32'd0);
    xfer(1'b0, 1'b0, 32'h1C, 32'd0, rd, er, cyc);
    check("rst_id_value", rd, ID);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
